// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Channel settings use CFG_W-wide fields; clamp_cfg() maps raw writes into legal settings.
package clk_div_pkg;

  localparam int CFG_W   = 8;
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] offset;
  } chan_cfg_t;

  // Clamp so that div>=2, 1<=high<div and offset<div.
  function automatic chan_cfg_t clamp_cfg(input chan_cfg_t c);
    chan_cfg_t r;
    r = c;
    if (r.div < CFG_W'(MIN_DIV)) r.div = CFG_W'(MIN_DIV);
    if (r.high == '0) r.high = CFG_W'(1);
    else if (r.high >= r.div) r.high = r.div - CFG_W'(1);
    if (r.offset >= r.div) r.offset = '0;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// Configuration and output bundle of clk_div_multi.
// master drives cfg/sync and observes the divided outputs; slave is the divider side.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CFG_W,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic [CNT_W-1:0]  cfg_offset;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] preedge;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_offset, sync,
    input  cfg_ready, clk_out, tick, preedge
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_offset, sync,
    output cfg_ready, clk_out, tick, preedge
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow settings and registered outputs.
// Define CLK_DIV_PREEDGE_EN to build the pre-edge strobe; otherwise preedge is tied low.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CFG_W,
  parameter int RST_DIV  = 4,
  parameter int RST_HIGH = 2
) (
  input  logic      CLK,
  input  logic      RST_N,
  input  logic      wr,
  input  chan_cfg_t cfg,
  input  logic      sync,
  output logic      pending,
  output logic      clk_out,
  output logic      tick,
  output logic      preedge
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam chan_cfg_t RST_CFG = '{div: CNT_W'(RST_DIV), high: CNT_W'(RST_HIGH), offset: '0};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  chan_cfg_t        act;
  chan_cfg_t        shd;
  chan_cfg_t        eff;
  logic             wrap;
  logic             apply;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    wrap     = (cnt == act.div - ONE);
    apply    = pending && (wrap || sync);
    eff      = apply ? shd : act;
    cnt_next = cnt + ONE;
    if (sync)      cnt_next = (eff.offset == '0) ? '0 : eff.div - eff.offset;
    else if (wrap) cnt_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt     <= CNT_W'(RST_DIV - 1);
      act     <= RST_CFG;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      act     <= eff;
      pending <= wr || (pending && !apply);
      clk_out <= (cnt_next < eff.high);
      tick    <= (cnt_next == '0);
    end
  end

  // NOTE: the shadow is only read while pending=1, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (wr) shd <= clamp_cfg(cfg);
  end

`ifdef CLK_DIV_PREEDGE_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) preedge <= 1'b0;
    else        preedge <= (cnt_next == eff.div - ONE);
  end
`else
  assign preedge = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider / enable generator.
// Optional pre-edge strobe is built only when CLK_DIV_PREEDGE_EN is defined.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = CFG_W,
  parameter int RST_DIV  = 4,
  parameter int RST_HIGH = 2
) (
  input logic      CLK,
  input logic      RST_N,
  clk_div_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("clk_div_multi: NUM_CH must be >= 1");
  end
  if (CNT_W != CFG_W) begin : g_bad_cnt_w
    $error("clk_div_multi: CNT_W must equal clk_div_pkg::CFG_W");
  end
  if (RST_DIV < MIN_DIV || RST_DIV >= 2**CNT_W) begin : g_bad_rst_div
    $error("clk_div_multi: RST_DIV out of range");
  end
  if (RST_HIGH < 1 || RST_HIGH >= RST_DIV) begin : g_bad_rst_high
    $error("clk_div_multi: RST_HIGH out of range");
  end

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] co;
  logic [NUM_CH-1:0] tk;
  logic [NUM_CH-1:0] pe;
  chan_cfg_t         cfg_in;

  // Channels outside NUM_CH always look ready so their writes are silently dropped.
  always_comb begin
    bus.cfg_ready = 1'b1;
    if (int'(bus.cfg_ch) < NUM_CH) bus.cfg_ready = !pend[bus.cfg_ch];
  end

  always_comb begin
    cfg_in = '{div: bus.cfg_div, high: bus.cfg_high, offset: bus.cfg_offset};
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = bus.cfg_valid && bus.cfg_ready && (bus.cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .RST_DIV  (RST_DIV),
      .RST_HIGH (RST_HIGH)
    ) u_chan (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .wr      (wr[i]),
      .cfg     (cfg_in),
      .sync    (bus.sync),
      .pending (pend[i]),
      .clk_out (co[i]),
      .tick    (tk[i]),
      .preedge (pe[i])
    );
  end

  assign bus.clk_out = co;
  assign bus.tick    = tk;
  assign bus.preedge = pe;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus queues hand-computed per-cycle expectations,
// a monitor pops one entry per clock and compares clk_out/tick/preedge/cfg_ready.
module tb_clk_div_multi;

  logic clk;
  logic rst_n;

  clk_div_if #(.NUM_CH(2), .CNT_W(8)) bus ();

  clk_div_multi #(
    .NUM_CH   (2),
    .CNT_W    (8),
    .RST_DIV  (4),
    .RST_HIGH (2)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      nm;
    logic [1:0] co;
    logic [1:0] tk;
    logic [1:0] pe;
    logic [1:0] pe_mask;
    logic       rdy;
    bit         chk_rdy;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit is1(input byte ch);
    return ch == 8'h31;
  endfunction

  // One expectation per cycle; strings are ch0/ch1 clk_out and tick, plus cfg_ready ("" = skip).
  // Expected preedge is the next character of the tick string (the cycle before a tick).
  task automatic run_pat(input string nm, input string c0, input string t0,
                         input string c1, input string t1, input string rd);
    for (int i = 0; i < c0.len(); i++) begin
      exp_t e;
      e.nm      = nm;
      e.co      = {is1(c1[i]), is1(c0[i])};
      e.tk      = {is1(t1[i]), is1(t0[i])};
      e.pe      = 2'b00;
      e.pe_mask = 2'b00;
`ifdef CLK_DIV_PREEDGE_EN
      if (i + 1 < t0.len()) begin
        e.pe_mask = 2'b11;
        e.pe      = {is1(t1[i+1]), is1(t0[i+1])};
      end
`else
      e.pe_mask = 2'b11;
`endif
      e.chk_rdy = 1'b0;
      e.rdy     = 1'b0;
      if (rd.len() > 0) begin
        e.chk_rdy = 1'b1;
        e.rdy     = is1(rd[i]);
      end
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input logic v, input logic ch, input int d, input int h, input int o);
    bus.cfg_valid  = v;
    bus.cfg_ch     = ch;
    bus.cfg_div    = 8'(d);
    bus.cfg_high   = 8'(h);
    bus.cfg_offset = 8'(o);
  endtask

  // Monitor: outputs settle after the posedge; compare 2 time units later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.nm, "_clk_out"}, 8'(bus.clk_out), 8'(e.co));
        check({e.nm, "_tick"}, 8'(bus.tick), 8'(e.tk));
        if (e.pe_mask != 2'b00)
          check({e.nm, "_preedge"}, 8'(bus.preedge & e.pe_mask), 8'(e.pe & e.pe_mask));
        if (e.chk_rdy)
          check({e.nm, "_cfg_ready"}, 8'(bus.cfg_ready), 8'(e.rdy));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    bus.sync = 1'b0;
    set_cfg(1'b0, 1'b0, 0, 0, 0);

    // Reset: outputs low, ready high.
    run_pat("reset", "00", "00", "00", "00", "11");

    // Reset pattern 1100 with tick on first post-reset cycle.
    rst_n = 1'b1;
    run_pat("t1", "110011001100", "100010001000", "110011001100", "100010001000", "111111111111");

    // ch0 div=5 high=2 written mid-stream; current period completes first.
    set_cfg(1'b1, 1'b0, 5, 2, 0);
    run_pat("t2_acc", "1", "1", "1", "1", "0");
    set_cfg(1'b0, 1'b0, 5, 2, 0);
    run_pat("t2_apply", "1001100011000", "0001000010000", "1001100110011", "0001000100010", "0001111111111");

    // div=0 high=9 clamps to div=2 high=1.
    set_cfg(1'b1, 1'b0, 0, 9, 0);
    run_pat("t3_acc", "1", "1", "0", "0", "0");
    set_cfg(1'b0, 1'b0, 0, 9, 0);
    run_pat("t3_clamp", "1000101010", "0000101010", "0110011001", "0100010001", "0000111111");

    // Both div=8 high=4, ch1 offset 3, then sync applies pending shadows and realigns.
    set_cfg(1'b1, 1'b0, 8, 4, 0);
    run_pat("t4_wr0", "1", "1", "1", "0", "0");
    set_cfg(1'b1, 1'b1, 8, 4, 3);
    run_pat("t4_wr1", "0", "0", "0", "0", "0");
    set_cfg(1'b0, 1'b1, 8, 4, 3);
    bus.sync = 1'b1;
    run_pat("t4_sync", "1", "1", "0", "0", "1");
    bus.sync = 1'b0;
    run_pat("t4_spacing", "11100001111", "00000001000", "00111100001", "00100000001", "11111111111");

    // Second write while pending is blocked; the first (div=4 high=1) wins.
    set_cfg(1'b1, 1'b0, 4, 1, 0);
    run_pat("t5_wr", "0", "0", "1", "0", "0");
    set_cfg(1'b1, 1'b0, 3, 1, 0);
    run_pat("t5_blocked", "0001", "0001", "1100", "0000", "0001");
    set_cfg(1'b0, 1'b0, 3, 1, 0);
    run_pat("t5_after", "00010001", "00010001", "00111100", "00100000", "11111111");

    // Reset with ch1 write pending: pending dropped, reset pattern resumes.
    set_cfg(1'b1, 1'b1, 10, 5, 0);
    run_pat("t6_wr", "0", "0", "0", "0", "0");
    set_cfg(1'b0, 1'b1, 10, 5, 0);
    rst_n = 1'b0;
    run_pat("t6_rst", "00", "00", "00", "00", "11");
    rst_n = 1'b1;
    run_pat("t6_resume", "110011001100", "100010001000", "110011001100", "100010001000", "111111111111");

    repeat (2) @(negedge clk);
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
